// File: rtl/rvbridge_pkg.sv
// ---------------------------------------------------------------------------
// rvbridge_pkg
//   Definitions shared by the rvbridge encoder and decoder:
//   - Avalon-ST Video packet type codes carried in the header nibble
//   - decoder state encoding
//   - number of beats a control packet occupies for a given plane count
// ---------------------------------------------------------------------------
package rvbridge_pkg;

    localparam logic [3:0] PKT_VIDEO    = 4'h0;
    localparam logic [3:0] PKT_CTRL     = 4'hF;

    // A control packet body carries nine nibbles: four width, four height
    // and one interlace nibble.
    localparam int         CTRL_NIBBLES = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CTRL    = 2'd1,
        ST_VIDEO   = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    // Body beats needed to hold all control nibbles: 9, 5 or 3 for
    // one, two or three planes.
    function automatic int ctrl_beats(input int planes);
        return (CTRL_NIBBLES + planes - 1) / planes;
    endfunction

endpackage

// File: rtl/rvbridge_ctrl_parse.sv
// ---------------------------------------------------------------------------
// rvbridge_ctrl_parse
//   Collects the nine nibbles of a control packet body and commits them as
//   width/height/interlace when the packet ends with all beats present.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   i_beat         body beat data
//   i_accept       a body beat (non-SOP) of a control packet is accepted
//   i_eop          the accepted beat is the last of the packet
//   i_start        a control header was accepted; restart collection
//   o_width        committed width   {n0,n1,n2,n3}
//   o_height       committed height  {n4,n5,n6,n7}
//   o_interlaced   committed interlace nibble n8
//   o_update       one-cycle pulse after a commit
//   o_valid        sticky, set by the first commit
//   o_short_err    one-cycle pulse when a packet ended too early
// ---------------------------------------------------------------------------
module rvbridge_ctrl_parse
    import rvbridge_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_BITS   = 8,
    parameter int DATA_PLANES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] i_beat,
    input  logic                  i_accept,
    input  logic                  i_eop,
    input  logic                  i_start,
    output logic [15:0]           o_width,
    output logic [15:0]           o_height,
    output logic [3:0]            o_interlaced,
    output logic                  o_update,
    output logic                  o_valid,
    output logic                  o_short_err
);

    localparam int NBEATS = ctrl_beats(DATA_PLANES);

    logic [3:0]  r_beat_cnt;
    logic [3:0]  r_nib [CTRL_NIBBLES];
    logic [15:0] r_width;
    logic [15:0] r_height;
    logic [3:0]  r_interlaced;
    logic        r_update;
    logic        r_valid;
    logic        r_short_err;

    logic [3:0]  w_nib [CTRL_NIBBLES];
    logic        w_complete;
    logic        w_unused_beat;

    // Only the low nibble of each plane carries control data.
    assign w_unused_beat = &{1'b0, i_beat};

    // Nibble view including the beat being accepted this cycle, so the
    // commit on the EOP beat sees that beat's nibbles too. Nibble k lives
    // in body beat k/DATA_PLANES, plane k%DATA_PLANES.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; otherwise a latch is inferred.
    always_comb begin
        for (int k = 0; k < CTRL_NIBBLES; k++) begin
            w_nib[k] = r_nib[k];
            if (i_accept && (r_beat_cnt == 4'(k / DATA_PLANES)))
                w_nib[k] = i_beat[(k % DATA_PLANES)*DATA_BITS +: 4];
        end
    end

    // Counter saturates at NBEATS, so any count here includes this beat.
    assign w_complete = (5'(r_beat_cnt) + 5'd1) >= 5'(NBEATS);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_beat_cnt   <= '0;
            // NOTE: the nibble store is a handful of flops, not a RAM, so it
            // is cleared by reset like any other register.
            for (int k = 0; k < CTRL_NIBBLES; k++) r_nib[k] <= '0;
            r_width      <= '0;
            r_height     <= '0;
            r_interlaced <= '0;
            r_update     <= 1'b0;
            r_valid      <= 1'b0;
            r_short_err  <= 1'b0;
        end else begin
            r_update    <= 1'b0;
            r_short_err <= 1'b0;
            if (i_start) begin
                r_beat_cnt <= '0;
                for (int k = 0; k < CTRL_NIBBLES; k++) r_nib[k] <= '0;
            end else if (i_accept) begin
                for (int k = 0; k < CTRL_NIBBLES; k++) r_nib[k] <= w_nib[k];
                if (r_beat_cnt != 4'(NBEATS)) r_beat_cnt <= r_beat_cnt + 4'd1;
                if (i_eop) begin
                    r_beat_cnt <= '0;
                    if (w_complete) begin
                        r_width      <= {w_nib[0], w_nib[1], w_nib[2], w_nib[3]};
                        r_height     <= {w_nib[4], w_nib[5], w_nib[6], w_nib[7]};
                        r_interlaced <= w_nib[8];
                        r_update     <= 1'b1;
                        r_valid      <= 1'b1;
                    end else begin
                        r_short_err  <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_width      = r_width;
    assign o_height     = r_height;
    assign o_interlaced = r_interlaced;
    assign o_update     = r_update;
    assign o_valid      = r_valid;
    assign o_short_err  = r_short_err;

endmodule

// File: rtl/rvbridge_decode.sv
// ---------------------------------------------------------------------------
// rvbridge_decode
//   Avalon-ST Video to raw video bridge. Control packets (type 0xF) update
//   the video_* outputs; video packets (type 0x0) lose their header and are
//   passed through with zero latency; other packet types are dropped.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   din_*                       Avalon-ST Video sink (data/valid/ready/SOP/EOP)
//   dout_*                      raw pixel source (data/valid/ready/SOP/EOP)
//   video_width/height          last committed frame size
//   video_interlaced            last committed interlace nibble
//   ctrl_update                 one-cycle pulse on a commit
//   ctrl_valid                  sticky, a control packet has been committed
//   pkt_error                   one-cycle pulse on a protocol error
// ---------------------------------------------------------------------------
module rvbridge_decode
    import rvbridge_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_BITS   = 8,
    parameter int DATA_PLANES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    output logic [15:0]           video_width,
    output logic [15:0]           video_height,
    output logic [3:0]            video_interlaced,
    output logic                  ctrl_update,
    output logic                  ctrl_valid,
    output logic                  pkt_error
);

    state_t     r_state;
    logic       r_first_pix;
    logic       r_hdr_err;

    logic       w_accept;
    logic       w_hdr;
    logic [3:0] w_type;
    logic       w_ctrl_accept;
    logic       w_ctrl_start;
    logic       w_short_err;

    assign w_accept      = din_valid & din_ready;
    // Any accepted SOP beat is a header, whatever state we are in.
    assign w_hdr         = w_accept & din_startofpacket;
    assign w_type        = din_data[3:0];
    assign w_ctrl_start  = w_hdr & (w_type == PKT_CTRL);
    assign w_ctrl_accept = w_accept & ~din_startofpacket & (r_state == ST_CTRL);

    // Handshake and output qualification. An SOP beat seen in VIDEO is a
    // new header: it is taken regardless of dout_ready and never shown
    // downstream.
    assign dout_data = din_data;

    always_comb begin
        din_ready          = 1'b1;
        dout_valid         = 1'b0;
        dout_startofpacket = 1'b0;
        dout_endofpacket   = 1'b0;
        if (r_state == ST_VIDEO) begin
            din_ready          = din_startofpacket ? 1'b1 : dout_ready;
            dout_valid         = din_valid & ~din_startofpacket;
            dout_startofpacket = dout_valid & r_first_pix;
            dout_endofpacket   = dout_valid & din_endofpacket;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_first_pix <= 1'b0;
            r_hdr_err   <= 1'b0;
        end else begin
            r_hdr_err <= 1'b0;
            if (w_hdr) begin
                // Header mid-packet aborts the old packet; a control header
                // that is also its own EOP carries no body.
                r_hdr_err   <= (r_state != ST_IDLE) ||
                               ((w_type == PKT_CTRL) && din_endofpacket);
                r_first_pix <= (w_type == PKT_VIDEO) && !din_endofpacket;
                if (din_endofpacket)
                    r_state <= ST_IDLE;
                else if (w_type == PKT_CTRL)
                    r_state <= ST_CTRL;
                else if (w_type == PKT_VIDEO)
                    r_state <= ST_VIDEO;
                else
                    r_state <= ST_DISCARD;
            end else if (w_accept) begin
                case (r_state)
                    ST_IDLE: ;  // stray non-SOP beats are dropped
                    ST_VIDEO: begin
                        r_first_pix <= 1'b0;
                        if (din_endofpacket) r_state <= ST_IDLE;
                    end
                    ST_CTRL, ST_DISCARD: begin
                        if (din_endofpacket) r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    rvbridge_ctrl_parse #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DATA_BITS   (DATA_BITS),
        .DATA_PLANES (DATA_PLANES)
    ) u_ctrl_parse (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_beat       (din_data),
        .i_accept     (w_ctrl_accept),
        .i_eop        (din_endofpacket),
        .i_start      (w_ctrl_start),
        .o_width      (video_width),
        .o_height     (video_height),
        .o_interlaced (video_interlaced),
        .o_update     (ctrl_update),
        .o_valid      (ctrl_valid),
        .o_short_err  (w_short_err)
    );

    // Both sources are registered pulses and cannot coincide: one needs an
    // SOP beat, the other a non-SOP EOP beat.
    assign pkt_error = r_hdr_err | w_short_err;

endmodule
